// File: rtl/uart_rx_deserializer.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling, start-glitch rejection,
// valid/ack holding register with framing-error pulse and sticky overrun.
module uart_rx_deserializer #(
  parameter int unsigned CLKS_PER_BIT = 5208
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxd,
  input  logic       rx_ack,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       busy,
  output logic       frame_err,
  output logic       overrun
);

  localparam int unsigned   CW      = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LP_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] LP_FULL = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t          r_state;
  logic            r_sync1;
  logic            r_sync2;
  logic [CW-1:0]   r_cnt;
  logic [2:0]      r_bit;
  logic [7:0]      r_shift;
  logic            w_rxd_s;
  logic            w_ack;

  assign w_rxd_s = r_sync2;
  assign w_ack   = rx_ack & rx_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_sync1   <= 1'b1;
      r_sync2   <= 1'b1;
      r_cnt     <= '0;
      r_bit     <= '0;
      r_shift   <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      busy      <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      r_sync1   <= rxd;
      r_sync2   <= r_sync1;
      frame_err <= 1'b0;

      // Ack is applied first so a byte loading in the same cycle overrides the clear.
      if (w_ack) begin
        rx_valid <= 1'b0;
        overrun  <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          if (!w_rxd_s) begin
            r_state <= S_START;
            r_cnt   <= '0;
            busy    <= 1'b1;
          end
        end

        S_START: begin
          if (r_cnt == LP_HALF) begin
            r_cnt <= '0;
            if (!w_rxd_s) begin
              r_state <= S_DATA;
              r_bit   <= '0;
            end else begin
              r_state <= S_IDLE;
              busy    <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        S_DATA: begin
          if (r_cnt == LP_FULL) begin
            r_cnt   <= '0;
            r_shift <= {w_rxd_s, r_shift[7:1]};
            r_bit   <= r_bit + 1'b1;
            if (r_bit == 3'd7) begin
              r_state <= S_STOP;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        S_STOP: begin
          if (r_cnt == LP_FULL) begin
            r_cnt <= '0;
            if (w_rxd_s) begin
              r_state <= S_IDLE;
              busy    <= 1'b0;
              if (!rx_valid || rx_ack) begin
                rx_data  <= r_shift;
                rx_valid <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
            end else begin
              frame_err <= 1'b1;
              r_state   <= S_BREAK;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        S_BREAK: begin
          if (w_rxd_s) begin
            r_state <= S_IDLE;
            busy    <= 1'b0;
          end
        end

        default: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
